// File: rtl/lsu_bus_master_pkg.sv
// Shared types, codes and lane helpers for the data-memory bus master.
package lsu_bus_master_pkg;

   localparam logic [4:0] FCT5_ADD  = 5'b00000;
   localparam logic [4:0] FCT5_SWAP = 5'b00001;
   localparam logic [4:0] FCT5_LR   = 5'b00010;
   localparam logic [4:0] FCT5_SC   = 5'b00011;
   localparam logic [4:0] FCT5_XOR  = 5'b00100;
   localparam logic [4:0] FCT5_OR   = 5'b01000;
   localparam logic [4:0] FCT5_AND  = 5'b01100;
   localparam logic [4:0] FCT5_MIN  = 5'b10000;
   localparam logic [4:0] FCT5_MAX  = 5'b10100;
   localparam logic [4:0] FCT5_MINU = 5'b11000;
   localparam logic [4:0] FCT5_MAXU = 5'b11100;

   localparam logic [63:0] MCAUSE_LOAD_MISALIGNED  = 64'd4;
   localparam logic [63:0] MCAUSE_STORE_MISALIGNED = 64'd6;

   typedef enum logic [2:0] {
      LSU_ST_IDLE    = 3'd0,
      LSU_ST_RD_REQ  = 3'd1,
      LSU_ST_RD_RESP = 3'd2,
      LSU_ST_WR_REQ  = 3'd3,
      LSU_ST_WR_RESP = 3'd4,
      LSU_ST_DONE    = 3'd5
   } lsu_state_e;

   typedef enum logic [2:0] {
      OP_LOAD  = 3'd0,
      OP_LR    = 3'd1,
      OP_STORE = 3'd2,
      OP_SC    = 3'd3,
      OP_AMO   = 3'd4
   } lsu_op_e;

   function automatic logic [7:0] byte_mask(input logic [1:0] size);
      unique case (size)
         2'd0:    byte_mask = 8'h01;
         2'd1:    byte_mask = 8'h03;
         2'd2:    byte_mask = 8'h0F;
         default: byte_mask = 8'hFF;
      endcase
   endfunction

   function automatic logic [2:0] align_mask(input logic [1:0] size);
      unique case (size)
         2'd0:    align_mask = 3'b000;
         2'd1:    align_mask = 3'b001;
         2'd2:    align_mask = 3'b011;
         default: align_mask = 3'b111;
      endcase
   endfunction

   function automatic logic [7:0] lane_wstrb(input logic [2:0] off,
                                             input logic [1:0] size);
      lane_wstrb = byte_mask(size) << off;
   endfunction

   function automatic logic [63:0] lane_wdata(input logic [63:0] d,
                                              input logic [2:0]  off,
                                              input logic [1:0]  size);
      logic [7:0]  bm;
      logic [63:0] m;
      bm = byte_mask(size);
      for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{bm[i]}};
      lane_wdata = (d & m) << {off, 3'b000};
   endfunction

   // f3[2] selects zero extension; size in f3[1:0]
   function automatic logic [63:0] lane_extract(input logic [63:0] d,
                                                input logic [2:0]  off,
                                                input logic [2:0]  f3);
      logic [63:0] s;
      s = d >> {off, 3'b000};
      unique case (f3[1:0])
         2'd0:    lane_extract = f3[2] ? {56'd0, s[7:0]}
                                       : {{56{s[7]}}, s[7:0]};
         2'd1:    lane_extract = f3[2] ? {48'd0, s[15:0]}
                                       : {{48{s[15]}}, s[15:0]};
         2'd2:    lane_extract = f3[2] ? {32'd0, s[31:0]}
                                       : {{32{s[31]}}, s[31:0]};
         default: lane_extract = s;
      endcase
   endfunction

endpackage

// File: rtl/lsu_amo_alu.sv
// Combinational AMO read-modify-write datapath: new = op(old, operand).
module lsu_amo_alu
   import lsu_bus_master_pkg::*;
(
   input  logic [63:0] old_i,
   input  logic [63:0] opnd_i,
   input  logic [4:0]  funct5_i,
   input  logic        is_word_i,
   output logic [63:0] new_o
);

   logic [63:0] a;
   logic [63:0] b;
   logic [63:0] r;
   logic        lt_s;
   logic        lt_u;

   always_comb begin
      // sign-extending both words keeps signed and unsigned order intact
      a = is_word_i ? {{32{old_i[31]}}, old_i[31:0]} : old_i;
      b = is_word_i ? {{32{opnd_i[31]}}, opnd_i[31:0]} : opnd_i;
      lt_s = $signed(a) < $signed(b);
      lt_u = a < b;
      case (funct5_i)
         FCT5_ADD:  r = a + b;
         FCT5_XOR:  r = a ^ b;
         FCT5_OR:   r = a | b;
         FCT5_AND:  r = a & b;
         FCT5_MIN:  r = lt_s ? a : b;
         FCT5_MAX:  r = lt_s ? b : a;
         FCT5_MINU: r = lt_u ? a : b;
         FCT5_MAXU: r = lt_u ? b : a;
         default:   r = b;
      endcase
      new_o = is_word_i ? {{32{r[31]}}, r[31:0]} : r;
   end

endmodule

// File: rtl/lsu_bus_master.sv
// Memory-stage initiator: one or two valid/ready bus transactions per
// load/store/atomic, with lane alignment, extension and LR/SC reservation.
module lsu_bus_master
   import lsu_bus_master_pkg::*;
#(
   parameter logic [63:0] PMEM_START = 64'h8000_0000
)(
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid_i,
   input  logic        load_i,
   input  logic        store_i,
   input  logic [2:0]  funct3_i,
   input  logic [63:0] addr_i,
   input  logic [63:0] sdata_i,
   input  logic        rva_valid_i,
   input  logic [4:0]  funct5_i,
   output logic        stall_o,
   output logic        resp_valid_o,
   output logic [63:0] rdata_o,
   output logic        exception_o,
   output logic [63:0] mcause_o,
   output logic        bus_req_valid_o,
   input  logic        bus_req_ready_i,
   output logic        bus_req_write_o,
   output logic [63:0] bus_req_addr_o,
   output logic [63:0] bus_req_wdata_o,
   output logic [7:0]  bus_req_wstrb_o,
   input  logic        bus_resp_valid_i,
   output logic        bus_resp_ready_o,
   input  logic [63:0] bus_resp_rdata_i
);

   lsu_state_e  state_q, state_d;
   lsu_op_e     op_q, op_d;
   logic [2:0]  f3_q, f3_d;
   logic [4:0]  f5_q, f5_d;
   logic [63:0] addr_q, addr_d;
   logic [63:0] sdata_q, sdata_d;
   logic [63:0] result_q, result_d;
   logic        resv_valid_q, resv_valid_d;
   logic [63:0] resv_addr_q, resv_addr_d;
   logic        breq_valid_q, breq_valid_d;
   logic        breq_write_q, breq_write_d;
   logic [63:0] breq_addr_q, breq_addr_d;
   logic [63:0] breq_wdata_q, breq_wdata_d;
   logic [7:0]  breq_wstrb_q, breq_wstrb_d;

   lsu_op_e     new_op;
   logic        is_mem;
   logic        misal;
   logic        sc_hit;
   logic        stall_c;
   logic        exc_c;
   logic [63:0] mcause_c;
   logic [63:0] bus_addr;
   logic [2:0]  ext_f3;
   logic [63:0] old_ext;
   logic [63:0] amo_new;

   always_comb begin
      is_mem   = req_valid_i & (load_i | store_i);
      misal    = |(addr_i[2:0] & align_mask(funct3_i[1:0]));
      bus_addr = (addr_i - PMEM_START) & ~64'h7;
      sc_hit   = resv_valid_q & (resv_addr_q == addr_i);
      if (load_i)
         new_op = rva_valid_i ? OP_LR : OP_LOAD;
      else if (rva_valid_i)
         new_op = (funct5_i == FCT5_SC) ? OP_SC : OP_AMO;
      else
         new_op = OP_STORE;
      // AMO.W loads always sign-extend
      ext_f3  = (op_q == OP_AMO) ? {1'b0, f3_q[1:0]} : f3_q;
      old_ext = lane_extract(bus_resp_rdata_i, addr_q[2:0], ext_f3);
   end

   lsu_amo_alu u_amo (
      .old_i     (old_ext),
      .opnd_i    (sdata_q),
      .funct5_i  (f5_q),
      .is_word_i (f3_q[1:0] == 2'b10),
      .new_o     (amo_new)
   );

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      f3_d         = f3_q;
      f5_d         = f5_q;
      addr_d       = addr_q;
      sdata_d      = sdata_q;
      result_d     = result_q;
      resv_valid_d = resv_valid_q;
      resv_addr_d  = resv_addr_q;
      breq_valid_d = breq_valid_q;
      breq_write_d = breq_write_q;
      breq_addr_d  = breq_addr_q;
      breq_wdata_d = breq_wdata_q;
      breq_wstrb_d = breq_wstrb_q;
      stall_c      = 1'b0;
      exc_c        = 1'b0;
      mcause_c     = 64'd0;
      unique case (state_q)
         LSU_ST_IDLE: begin
            if (is_mem && misal) begin
               exc_c    = 1'b1;
               mcause_c = store_i ? MCAUSE_STORE_MISALIGNED
                                  : MCAUSE_LOAD_MISALIGNED;
            end else if (is_mem) begin
               stall_c      = 1'b1;
               op_d         = new_op;
               f3_d         = funct3_i;
               f5_d         = funct5_i;
               addr_d       = addr_i;
               sdata_d      = sdata_i;
               result_d     = 64'd0;
               breq_addr_d  = bus_addr;
               breq_write_d = 1'b1;
               breq_wdata_d = lane_wdata(sdata_i, addr_i[2:0], funct3_i[1:0]);
               breq_wstrb_d = lane_wstrb(addr_i[2:0], funct3_i[1:0]);
               unique case (new_op)
                  OP_LOAD, OP_LR, OP_AMO: begin
                     state_d      = LSU_ST_RD_REQ;
                     breq_valid_d = 1'b1;
                     breq_write_d = 1'b0;
                     breq_wdata_d = 64'd0;
                     breq_wstrb_d = 8'd0;
                  end
                  OP_SC: begin
                     resv_valid_d = 1'b0;
                     if (sc_hit) begin
                        state_d      = LSU_ST_WR_REQ;
                        breq_valid_d = 1'b1;
                     end else begin
                        state_d  = LSU_ST_DONE;
                        result_d = 64'd1;
                     end
                  end
                  default: begin
                     state_d      = LSU_ST_WR_REQ;
                     breq_valid_d = 1'b1;
                  end
               endcase
            end
         end
         LSU_ST_RD_REQ: begin
            stall_c = 1'b1;
            if (bus_req_ready_i) begin
               breq_valid_d = 1'b0;
               state_d      = LSU_ST_RD_RESP;
            end
         end
         LSU_ST_RD_RESP: begin
            stall_c = 1'b1;
            if (bus_resp_valid_i) begin
               result_d = old_ext;
               if (op_q == OP_AMO) begin
                  state_d      = LSU_ST_WR_REQ;
                  breq_valid_d = 1'b1;
                  breq_write_d = 1'b1;
                  breq_wdata_d = lane_wdata(amo_new, addr_q[2:0], f3_q[1:0]);
                  breq_wstrb_d = lane_wstrb(addr_q[2:0], f3_q[1:0]);
               end else begin
                  state_d = LSU_ST_DONE;
                  if (op_q == OP_LR) begin
                     resv_valid_d = 1'b1;
                     resv_addr_d  = addr_q;
                  end
               end
            end
         end
         LSU_ST_WR_REQ: begin
            stall_c = 1'b1;
            if (bus_req_ready_i) begin
               breq_valid_d = 1'b0;
               state_d      = LSU_ST_WR_RESP;
            end
         end
         LSU_ST_WR_RESP: begin
            stall_c = 1'b1;
            if (bus_resp_valid_i) state_d = LSU_ST_DONE;
         end
         LSU_ST_DONE: begin
            state_d = LSU_ST_IDLE;
         end
         default: begin
            state_d = LSU_ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= LSU_ST_IDLE;
         op_q         <= OP_LOAD;
         f3_q         <= 3'd0;
         f5_q         <= 5'd0;
         addr_q       <= 64'd0;
         sdata_q      <= 64'd0;
         result_q     <= 64'd0;
         resv_valid_q <= 1'b0;
         resv_addr_q  <= 64'd0;
         breq_valid_q <= 1'b0;
         breq_write_q <= 1'b0;
         breq_addr_q  <= 64'd0;
         breq_wdata_q <= 64'd0;
         breq_wstrb_q <= 8'd0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         f3_q         <= f3_d;
         f5_q         <= f5_d;
         addr_q       <= addr_d;
         sdata_q      <= sdata_d;
         result_q     <= result_d;
         resv_valid_q <= resv_valid_d;
         resv_addr_q  <= resv_addr_d;
         breq_valid_q <= breq_valid_d;
         breq_write_q <= breq_write_d;
         breq_addr_q  <= breq_addr_d;
         breq_wdata_q <= breq_wdata_d;
         breq_wstrb_q <= breq_wstrb_d;
      end
   end

   // request-side combinational outputs are held at 0 during reset
   assign stall_o          = stall_c & ~reset;
   assign exception_o      = exc_c & ~reset;
   assign mcause_o         = reset ? 64'd0 : mcause_c;
   assign resp_valid_o     = (state_q == LSU_ST_DONE);
   assign rdata_o          = (state_q == LSU_ST_DONE) ? result_q : 64'd0;
   assign bus_req_valid_o  = breq_valid_q;
   assign bus_req_write_o  = breq_write_q;
   assign bus_req_addr_o   = breq_addr_q;
   assign bus_req_wdata_o  = breq_wdata_q;
   assign bus_req_wstrb_o  = breq_wstrb_q;
   assign bus_resp_ready_o = (state_q == LSU_ST_RD_RESP) ||
                             (state_q == LSU_ST_WR_RESP);

endmodule

// File: tb/tb_lsu_bus_master.sv
// Scoreboard bench for lsu_bus_master: byte-level memory model, bus
// responder with random back-pressure, and an independent result monitor.
module tb_lsu_bus_master;

   localparam logic [63:0] BASE = 64'h8000_0000;
   localparam logic [4:0] F_ADD = 5'b00000, F_SWAP = 5'b00001;
   localparam logic [4:0] F_LR = 5'b00010, F_SC = 5'b00011;
   localparam logic [4:0] F_XOR = 5'b00100, F_OR = 5'b01000;
   localparam logic [4:0] F_AND = 5'b01100, F_MIN = 5'b10000;
   localparam logic [4:0] F_MAX = 5'b10100, F_MINU = 5'b11000;
   localparam logic [4:0] F_MAXU = 5'b11100;

   logic clock = 0, reset;
   logic req_valid_i, load_i, store_i, rva_valid_i;
   logic [2:0] funct3_i;
   logic [63:0] addr_i, sdata_i;
   logic [4:0] funct5_i;
   logic stall_o, resp_valid_o, exception_o;
   logic [63:0] rdata_o, mcause_o;
   logic bus_req_valid_o, bus_req_ready_i, bus_req_write_o;
   logic [63:0] bus_req_addr_o, bus_req_wdata_o;
   logic [7:0] bus_req_wstrb_o;
   logic bus_resp_valid_i, bus_resp_ready_o;
   logic [63:0] bus_resp_rdata_i;

   lsu_bus_master #(.PMEM_START(BASE)) dut (
      .clock(clock), .reset(reset),
      .req_valid_i(req_valid_i), .load_i(load_i), .store_i(store_i),
      .funct3_i(funct3_i), .addr_i(addr_i), .sdata_i(sdata_i),
      .rva_valid_i(rva_valid_i), .funct5_i(funct5_i),
      .stall_o(stall_o), .resp_valid_o(resp_valid_o), .rdata_o(rdata_o),
      .exception_o(exception_o), .mcause_o(mcause_o),
      .bus_req_valid_o(bus_req_valid_o), .bus_req_ready_i(bus_req_ready_i),
      .bus_req_write_o(bus_req_write_o), .bus_req_addr_o(bus_req_addr_o),
      .bus_req_wdata_o(bus_req_wdata_o), .bus_req_wstrb_o(bus_req_wstrb_o),
      .bus_resp_valid_i(bus_resp_valid_i), .bus_resp_ready_o(bus_resp_ready_o),
      .bus_resp_rdata_i(bus_resp_rdata_i)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic exc; logic [63:0] mcause; logic [63:0] rdata; logic chk;
   } exp_t;
   typedef struct {
      logic write; logic [63:0] addr; logic [63:0] wdata; logic [7:0] wstrb;
   } txn_t;

   exp_t exp_q[$];
   txn_t txn_q[$];
   logic [7:0]  rmem [0:255];
   logic [63:0] bmem [0:31];
   logic        resv = 0;
   logic [63:0] resv_addr = 0;
   int n_checks = 0, n_fail = 0;
   int fast = 0, holdoff = 0;
   logic [63:0] last_wdata = 0;
   logic [7:0]  last_wstrb = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic poke(input int off, input logic [63:0] d);
      bmem[off / 8] = d;
      for (int b = 0; b < 8; b++) rmem[off + b] = d[8*b +: 8];
   endtask

   function automatic logic [63:0] amo_ref(input logic [63:0] a,
      input logic [63:0] b, input logic [4:0] f5, input logic w);
      longint sa, sb;
      longint unsigned ua, ub;
      if (w) begin
         sa = longint'($signed(a[31:0])); sb = longint'($signed(b[31:0]));
         ua = {32'd0, a[31:0]}; ub = {32'd0, b[31:0]};
      end else begin
         sa = a; sb = b; ua = a; ub = b;
      end
      case (f5)
         F_ADD:   return sa + sb;
         F_XOR:   return a ^ b;
         F_OR:    return a | b;
         F_AND:   return a & b;
         F_MIN:   return (sa < sb) ? sa : sb;
         F_MAX:   return (sa > sb) ? sa : sb;
         F_MINU:  return (ua < ub) ? ua : ub;
         F_MAXU:  return (ua > ub) ? ua : ub;
         default: return b;
      endcase
   endfunction

   task automatic write_model(input int off, input int nb, input logic [63:0] d);
      txn_t t;
      int lo;
      lo = off % 8;
      t.write = 1; t.addr = 64'(off - lo); t.wdata = 0; t.wstrb = 0;
      for (int i = 0; i < nb; i++) begin
         rmem[off + i] = d[8*i +: 8];
         t.wstrb[lo + i] = 1'b1;
         t.wdata[8*(lo + i) +: 8] = d[8*i +: 8];
      end
      txn_q.push_back(t);
   endtask

   task automatic model(input logic ld, input logic st, input logic rva,
      input logic [2:0] f3, input int off, input logic [63:0] sd,
      input logic [4:0] f5);
      exp_t e;
      txn_t t;
      int nb;
      logic [63:0] old, a64;
      logic is_sc;
      if (!ld && !st) return;
      nb = 1 << f3[1:0];
      a64 = BASE + 64'(off);
      e.exc = 0; e.mcause = 0; e.rdata = 0; e.chk = 1;
      if (off % nb != 0) begin
         e.exc = 1; e.mcause = st ? 64'd6 : 64'd4;
         exp_q.push_back(e);
         return;
      end
      old = 0;
      for (int i = 0; i < nb; i++) old |= 64'(rmem[off + i]) << (8*i);
      if ((!f3[2] || (st && rva)) && nb < 8 && old[8*nb-1])
         old |= ~((64'd1 << (8*nb)) - 1);
      t.write = 0; t.addr = 64'(off - off % 8); t.wdata = 0; t.wstrb = 0;
      is_sc = st && rva && f5 == F_SC;
      if (ld) begin
         txn_q.push_back(t);
         if (rva) begin resv = 1; resv_addr = a64; end
         e.rdata = old;
      end else if (is_sc) begin
         if (resv && resv_addr == a64) begin
            write_model(off, nb, sd); e.rdata = 0;
         end else e.rdata = 1;
         resv = 0;
      end else if (rva) begin
         txn_q.push_back(t);
         write_model(off, nb, amo_ref(old, sd, f5, nb == 4));
         e.rdata = old;
      end else begin
         write_model(off, nb, sd);
         e.chk = 0;
      end
      exp_q.push_back(e);
   endtask

   task automatic issue(input logic ld, input logic st, input logic rva,
      input logic [2:0] f3, input int off, input logic [63:0] sd,
      input logic [4:0] f5, output int lat);
      model(ld, st, rva, f3, off, sd, f5);
      @(posedge clock); #1;
      req_valid_i = 1; load_i = ld; store_i = st; rva_valid_i = rva;
      funct3_i = f3; addr_i = BASE + 64'(off); sdata_i = sd; funct5_i = f5;
      lat = 0;
      while (1) begin
         @(negedge clock);
         if (!stall_o) break;
         lat++;
         if (lat > 500) begin check("timeout", 1, 0); break; end
      end
      @(posedge clock); #1;
      req_valid_i = 0; load_i = 0; store_i = 0; rva_valid_i = 0;
   endtask

   // result monitor
   always @(negedge clock) begin
      exp_t e;
      if (!reset && (resp_valid_o || exception_o)) begin
         if (exp_q.size() == 0) check("unexpected_resp", 1, 0);
         else begin
            e = exp_q.pop_front();
            check("resp_is_exc", 64'(exception_o), 64'(e.exc));
            if (e.exc) check("mcause", mcause_o, e.mcause);
            else if (e.chk) check("rdata", rdata_o, e.rdata);
         end
      end
   end

   // bus responder
   initial begin
      txn_t t, held;
      logic have_held, pend;
      logic [63:0] pend_data;
      int idx;
      have_held = 0; pend = 0; pend_data = 0;
      bus_req_ready_i = 0; bus_resp_valid_i = 0; bus_resp_rdata_i = 0;
      forever begin
         @(posedge clock); #1;
         bus_req_ready_i = 0; bus_resp_valid_i = 0;
         if (reset) begin
            pend = 0; have_held = 0;
         end else if (pend) begin
            if (bus_resp_ready_o && (fast != 0 || $urandom_range(0, 2) != 0)) begin
               bus_resp_valid_i = 1; bus_resp_rdata_i = pend_data; pend = 0;
            end
         end else if (bus_req_valid_o) begin
            if (have_held) begin
               check("hold_addr", bus_req_addr_o, held.addr);
               check("hold_wdata", bus_req_wdata_o, held.wdata);
               check("hold_wstrb", 64'(bus_req_wstrb_o), 64'(held.wstrb));
               check("hold_stall", 64'(stall_o), 64'd1);
            end
            if (holdoff > 0 || (fast == 0 && $urandom_range(0, 2) == 0)) begin
               if (holdoff > 0) holdoff--;
               have_held = 1;
               held.addr = bus_req_addr_o; held.wdata = bus_req_wdata_o;
               held.wstrb = bus_req_wstrb_o;
            end else begin
               have_held = 0;
               bus_req_ready_i = 1;
               if (txn_q.size() == 0) check("unexpected_bus_req", 1, 0);
               else begin
                  t = txn_q.pop_front();
                  check("bus_write", 64'(bus_req_write_o), 64'(t.write));
                  check("bus_addr", bus_req_addr_o, t.addr);
                  if (t.write) begin
                     check("bus_wdata", bus_req_wdata_o, t.wdata);
                     check("bus_wstrb", 64'(bus_req_wstrb_o), 64'(t.wstrb));
                  end
               end
               idx = int'(bus_req_addr_o[7:3]);
               if (bus_req_write_o) begin
                  last_wdata = bus_req_wdata_o; last_wstrb = bus_req_wstrb_o;
                  for (int b = 0; b < 8; b++)
                     if (bus_req_wstrb_o[b])
                        bmem[idx][8*b +: 8] = bus_req_wdata_o[8*b +: 8];
               end
               pend_data = bmem[idx];
               pend = 1;
            end
         end
      end
   end

   initial begin
      int lat, kind, off, nb, lr_off;
      logic [2:0] f3;
      logic [4:0] f5;
      logic [4:0] f5_tab [10];
      f5_tab = '{F_ADD, F_SWAP, F_XOR, F_OR, F_AND, F_MIN, F_MAX, F_MINU,
                 F_MAXU, 5'b11111};
      for (int i = 0; i < 32; i++) poke(i * 8, {$urandom, $urandom});
      reset = 1;
      req_valid_i = 1; load_i = 1; store_i = 0; rva_valid_i = 0;
      funct3_i = 3'd2; addr_i = BASE + 64'd2; sdata_i = 0; funct5_i = 0;
      @(negedge clock); @(negedge clock);
      check("rst_stall", 64'(stall_o), 0);
      check("rst_exc", 64'(exception_o), 0);
      check("rst_resp_valid", 64'(resp_valid_o), 0);
      check("rst_bus_req_valid", 64'(bus_req_valid_o), 0);
      check("rst_bus_resp_ready", 64'(bus_resp_ready_o), 0);
      check("rst_rdata", rdata_o, 0);
      @(posedge clock); #1;
      req_valid_i = 0; load_i = 0; reset = 0;

      fast = 1;
      poke(16, 64'h1122334455667788);
      issue(1, 0, 0, 3'b011, 16, 0, 0, lat);
      check("ld_latency", 64'(lat), 3);
      poke(16, 64'h0000000080000000);
      issue(1, 0, 0, 3'b000, 19, 0, 0, lat);
      issue(1, 0, 0, 3'b100, 19, 0, 0, lat);
      issue(0, 1, 0, 3'b001, 6, 64'hBEEF, 0, lat);
      check("sh_wstrb", 64'(last_wstrb), 64'hC0);
      check("sh_wdata", last_wdata, 64'hBEEF000000000000);
      poke(0, 64'h7FFFFFFF_00000000);
      issue(0, 1, 1, 3'b010, 4, 64'd1, F_ADD, lat);
      check("amo_latency", 64'(lat), 5);
      check("amo_wstrb", 64'(last_wstrb), 64'hF0);
      check("amo_wdata_hi", {32'd0, last_wdata[63:32]}, 64'h80000000);
      issue(1, 0, 1, 3'b011, 32, 0, F_LR, lat);
      issue(0, 1, 1, 3'b011, 32, 64'h5A5A, F_SC, lat);
      check("sc_ok_latency", 64'(lat), 3);
      issue(0, 1, 1, 3'b011, 32, 64'h7777, F_SC, lat);
      check("sc_fail_latency", 64'(lat), 1);
      issue(1, 0, 0, 3'b010, 2, 0, 0, lat);
      check("misal_latency", 64'(lat), 0);
      check("misal_no_bus", 64'(bus_req_valid_o), 0);
      holdoff = 5;
      issue(1, 0, 0, 3'b011, 40, 0, 0, lat);
      check("holdoff_latency", 64'(lat), 8);

      fast = 0;
      lr_off = 0;
      for (int n = 0; n < 400; n++) begin
         kind = $urandom_range(0, 5);
         f3 = 3'($urandom_range(0, 7));
         if (kind >= 2 && kind <= 4) f3 = {2'b01, 1'($urandom_range(0, 1))};
         nb = 1 << f3[1:0];
         off = $urandom_range(0, 255);
         if ($urandom_range(0, 4) != 0) off = off - off % nb;
         if (kind == 3 && $urandom_range(0, 1) == 1) off = lr_off;
         if (kind == 2) lr_off = off;
         f5 = f5_tab[$urandom_range(0, 9)];
         case (kind)
            0: issue(1, 0, 0, f3, off, {$urandom, $urandom}, 0, lat);
            1: issue(0, 1, 0, f3, off, {$urandom, $urandom}, 0, lat);
            2: issue(1, 0, 1, f3, off, 0, F_LR, lat);
            3: issue(0, 1, 1, f3, off, {$urandom, $urandom}, F_SC, lat);
            4: issue(0, 1, 1, f3, off, {$urandom, $urandom}, f5, lat);
            default: issue(0, 0, 0, f3, off, {$urandom, $urandom}, 0, lat);
         endcase
      end
      repeat (5) @(negedge clock);
      check("exp_drained", 64'(exp_q.size()), 0);
      check("txn_drained", 64'(txn_q.size()), 0);
      for (int i = 0; i < 32; i++)
         check("mem_final", bmem[i], {rmem[8*i+7], rmem[8*i+6], rmem[8*i+5],
               rmem[8*i+4], rmem[8*i+3], rmem[8*i+2], rmem[8*i+1], rmem[8*i]});
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_bus_master.md
# lsu_bus_master

Pipeline-side initiator for data memory: turns the memory stage's single-cycle load/store/atomic request into one or two transactions on a valid/ready data bus, and stalls the pipeline until the data bus responds. It owns lane alignment, byte strobes, load extension, the AMO read-modify-write sequence and the LR/SC reservation. It sits between the memory stage and the data-memory responder, replacing direct array access.

## Interface
- `PMEM_START`, default `64'h8000_0000`: physical memory base; the bus address is the offset from this base.
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `req_valid_i`  in  1  memory stage holds a memory operation; held stable while `stall_o`=1
- `load_i` / `store_i`  in  1 / 1  load, or store (AMO and SC assert `store_i`; LR asserts `load_i`)
- `funct3_i`  in  3  [1:0] size 0..3 = B/H/W/D; [2] unsigned load
- `addr_i`  in  64  virtual=physical byte address
- `sdata_i`  in  64  store data or AMO operand, LSB-aligned
- `rva_valid_i`  in  1  atomic instruction
- `funct5_i`  in  5  AMO opcode
- `stall_o`  out  1  freeze pipeline
- `resp_valid_o`  out  1  one-cycle pulse: `rdata_o` valid, request retired
- `rdata_o`  out  64  extended load data, AMO old value, or SC result
- `exception_o`  out  1  misaligned access, one-cycle pulse
- `mcause_o`  out  64  4 = load misaligned, 6 = store/AMO misaligned
- `bus_req_valid_o` / `bus_req_ready_i`  out / in  1 / 1  request handshake
- `bus_req_write_o`  out  1  1 = write
- `bus_req_addr_o`  out  64  `(addr_i - PMEM_START)` with [2:0] forced to 0
- `bus_req_wdata_o`  out  64  store data shifted to its byte lane
- `bus_req_wstrb_o`  out  8  byte enables
- `bus_resp_valid_i` / `bus_resp_ready_o`  in / out  1 / 1  response handshake; writes also get a response, with data ignored
- `bus_resp_rdata_i`  in  64  full aligned doubleword

## Operation
- FSM: IDLE, RD_REQ, RD_RESP, WR_REQ, WR_RESP, DONE.
- IDLE, with `req_valid_i` and a load or store:
  - Misaligned (`addr_i[size-1:0]`≠0): pulse `exception_o`, no bus traffic, stay in IDLE. `stall_o`=0.
  - Load, LR, or AMO: go to RD_REQ.
  - Plain store: go to WR_REQ.
  - SC: go to WR_REQ if the reservation is valid and its address equals `addr_i`; otherwise go to DONE with result 1.
  - In all these cases `stall_o`=1.
- RD_REQ:
  - Hold `bus_req_valid_o` until `bus_req_ready_i`, then go to RD_RESP.
- RD_RESP:
  - `bus_resp_ready_o`=1.
  - On `bus_resp_valid_i`, capture the data extracted from the lane as `old`: shift right by 8×addr[2:0], then sign- or zero-extend per `funct3_i`. AMO.W always sign-extends.
  - Load or LR: go to DONE. LR also sets reservation valid with address `addr_i`.
  - AMO: compute `new = amo(old, sdata_i)` and go to WR_REQ.
- WR_REQ:
  - wdata = (AMO ? new : sdata_i) << 8×addr[2:0].
  - wstrb = ((1<<2^size)−1) << addr[2:0].
  - Hold `bus_req_valid_o` until ready, then go to WR_RESP.
- WR_RESP:
  - On a response, go to DONE.
- DONE:
  - `resp_valid_o`=1, `stall_o`=0, go to IDLE.
  - `rdata_o` by operation: load or LR → `old`; AMO → `old`; SC → 0 on success, 1 on failure.
- Any SC, successful or not, clears the reservation.
- AMO ops: SWAP, ADD, AND, OR, XOR, MIN, MAX, MINU, MAXU. For .W, operate on bits [31:0] only and write 32 bits. Unknown funct5 behaves as SWAP.
- Requests with neither load nor store: no stall, no response.

## Timing
- Reset: FSM enters IDLE; the reservation is cleared; every output is 0.
- Reset mid-transaction abandons the transaction; the bus responder is reset by the same `reset`.
- `stall_o` is combinational: it is 1 in IDLE when a valid, aligned request is present, and 1 in all states except IDLE and DONE.
- Bus outputs are registered and stable while valid is high without ready.
- Minimum latency, with ready and response each in their first possible cycle:
  - load/store: accept at cycle 0, request at cycle 1, response at cycle 2, `resp_valid_o` at cycle 3.
  - AMO: `resp_valid_o` at cycle 5.
  - failed SC: `resp_valid_o` at cycle 1.
- Exactly one outstanding bus transaction. `bus_resp_ready_o` is only high in RD_RESP and WR_RESP.
- A response that arrives in the same cycle as request ready is not legal from the responder.

## Structure
- Shared header `define.v` gets:
  - `FCT5_*` codes (adds MIN/MAX/MINU/MAXU/SWAP);
  - `MCAUSE_LOAD_MISALIGNED` (4) and `MCAUSE_STORE_MISALIGNED` (6);
  - the `LSU_ST_*` state encodings.
- Sub-module `lsu_amo_alu`: combinational (old, operand, funct5, is_word) → new.

## Test plan
- LD from 0x80000010, bus returns 0x1122334455667788 → `bus_req_addr_o`=0x10, `rdata_o`=0x1122334455667788 at cycle 3.
- LB from 0x80000013 with bus data 0x00000000_80000000 → `rdata_o`=0xFFFFFFFFFFFFFF80; LBU gives 0x80.
- SH 0xBEEF to 0x80000006 → `bus_req_wstrb_o`=0xC0, `bus_req_wdata_o`=0xBEEF000000000000.
- AMOADD.W at 0x80000004, memory word 0x7FFFFFFF, operand 1 → write 0x80000000 in lanes [7:4] (wstrb 0xF0); `rdata_o`=0x7FFFFFFF.
- LR.D at 0x80000020, then SC.D at 0x80000020 → rd 0 with a write; a second SC.D → rd 1, no bus traffic.
- LW at 0x80000002 → `exception_o`=1, `mcause_o`=4, no `bus_req_valid_o`. Bus ready held low 5 cycles → `stall_o` held and the address stays stable.
